// File: rtl/can_frame_decoder.sv
// Receive-side decoder for extended-format CAN frames: destuffing, CRC-15, form checks, ACK request, ID field split.
// Optional feature macro: CAN_DEC_ADDR_FILTER_EN (only frames for NODE_ADDRESS or broadcast 6'h3F raise frame_valid_o).
module can_frame_decoder #(
  parameter logic [5:0] NODE_ADDRESS = 6'b100010
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // bit_valid_i is a one-cycle strobe with no back-pressure: every strobe carries
  // one bus bit on bit_i and is consumed in the cycle it arrives.
  input  logic        bit_valid_i,
  input  logic        bit_i,
  output logic        ack_o,
  output logic        busy_o,
  output logic        frame_valid_o,
  output logic        message_type_o,
  output logic [5:0]  local_address_o,
  output logic [5:0]  remote_address_o,
  output logic [1:0]  handshake_o,
  output logic [1:0]  attribute_o,
  output logic [3:0]  expand_count_o,
  output logic [7:0]  cmd_data_sign_o,
  output logic        rtr_o,
  output logic [3:0]  dlc_o,
  output logic [63:0] data_o,
  output logic        error_o,
  output logic [2:0]  error_code_o,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    WAIT_IDLE = 4'd0,
    IDLE      = 4'd1,
    ARB_A     = 4'd2,
    SRR       = 4'd3,
    IDE       = 4'd4,
    ARB_B     = 4'd5,
    RTR       = 4'd6,
    R1        = 4'd7,
    R0        = 4'd8,
    DLC       = 4'd9,
    DATA      = 4'd10,
    CRC       = 4'd11,
    CRC_DEL   = 4'd12,
    ACK_SLOT  = 4'd13,
    ACK_DEL   = 4'd14,
    EOF       = 4'd15
  } state_e;

  localparam logic [2:0] ERR_STUFF = 3'b001;
  localparam logic [2:0] ERR_FORM  = 3'b010;
  localparam logic [2:0] ERR_CRC   = 3'b011;

  state_e       state_q, state_d;
  logic [6:0]   cnt_q, cnt_d;
  logic [2:0]   run_q, run_d;
  logic         last_q, last_d;
  logic [14:0]  crc_q, crc_d;
  logic [14:0]  crc_rx_q, crc_rx_d;
  logic         crc_ok_q, crc_ok_d;
  logic [28:0]  id_q, id_d;
  logic         rtr_q, rtr_d;
  logic [3:0]   dlc_q, dlc_d;
  logic [63:0]  data_q, data_d;
  logic [6:0]   data_bits_q, data_bits_d;
  logic         ack_q, ack_d;
  logic         busy_q, busy_d;
  logic         valid_q, valid_d;
  logic         error_q, error_d;
  logic [2:0]   code_q, code_d;
  logic [28:0]  out_id_q, out_id_d;
  logic         out_rtr_q, out_rtr_d;
  logic [3:0]   out_dlc_q, out_dlc_d;
  logic [63:0]  out_data_q, out_data_d;

  logic         destuff_en;
  logic         err_fire;
  logic [2:0]   err_code;
  logic [3:0]   dlc_full;
  logic [6:0]   n_bits;
  logic         frame_accept;

  function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
    logic [14:0] sh;
    sh = {crc[13:0], 1'b0};
    return (b ^ crc[14]) ? (sh ^ 15'h4599) : sh;
  endfunction

`ifdef CAN_DEC_ADDR_FILTER_EN
  assign frame_accept = (id_q[21:16] == NODE_ADDRESS) || (id_q[21:16] == 6'h3F);
`else
  logic unused_node_address;
  assign unused_node_address = ^NODE_ADDRESS;
  assign frame_accept = 1'b1;
`endif

  // CRC_DEL is included so a stuff bit following the last CRC bit is still checked.
  assign destuff_en = (state_q == ARB_A) || (state_q == SRR) || (state_q == IDE) ||
                      (state_q == ARB_B) || (state_q == RTR) || (state_q == R1) ||
                      (state_q == R0) || (state_q == DLC) || (state_q == DATA) ||
                      (state_q == CRC) || (state_q == CRC_DEL);

  assign dlc_full = {dlc_q[2:0], bit_i};
  assign n_bits   = rtr_q ? 7'd0 : ((dlc_full > 4'd8) ? 7'd64 : {dlc_full, 3'b000});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_d       = run_q;
    last_d      = last_q;
    crc_d       = crc_q;
    crc_rx_d    = crc_rx_q;
    crc_ok_d    = crc_ok_q;
    id_d        = id_q;
    rtr_d       = rtr_q;
    dlc_d       = dlc_q;
    data_d      = data_q;
    data_bits_d = data_bits_q;
    ack_d       = ack_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    code_d      = code_q;
    out_id_d    = out_id_q;
    out_rtr_d   = out_rtr_q;
    out_dlc_d   = out_dlc_q;
    out_data_d  = out_data_q;
    err_fire    = 1'b0;
    err_code    = 3'b000;

    if (bit_valid_i) begin
      if (destuff_en && (run_q == 3'd5)) begin
        if (bit_i == last_q) begin
          err_fire = 1'b1;
          err_code = ERR_STUFF;
        end else begin
          run_d  = 3'd1;
          last_d = bit_i;
        end
      end else begin
        if (destuff_en) begin
          run_d  = (bit_i == last_q) ? run_q + 3'd1 : 3'd1;
          last_d = bit_i;
        end
        unique case (state_q)
          WAIT_IDLE: begin
            if (!bit_i) begin
              cnt_d = '0;
            end else if (cnt_q == 7'd10) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          IDLE: begin
            if (!bit_i) begin
              state_d     = ARB_A;
              cnt_d       = '0;
              run_d       = 3'd1;
              last_d      = 1'b0;
              crc_d       = '0;
              crc_rx_d    = '0;
              crc_ok_d    = 1'b0;
              id_d        = '0;
              rtr_d       = 1'b0;
              dlc_d       = '0;
              data_d      = '0;
              data_bits_d = '0;
            end
          end
          ARB_A: begin
            id_d  = {id_q[27:0], bit_i};
            crc_d = crc_step(crc_q, bit_i);
            if (cnt_q == 7'd10) begin
              cnt_d   = '0;
              state_d = SRR;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          SRR: begin
            crc_d = crc_step(crc_q, bit_i);
            if (!bit_i) begin
              err_fire = 1'b1;
              err_code = ERR_FORM;
            end else begin
              state_d = IDE;
            end
          end
          IDE: begin
            crc_d = crc_step(crc_q, bit_i);
            if (!bit_i) begin
              err_fire = 1'b1;
              err_code = ERR_FORM;
            end else begin
              state_d = ARB_B;
            end
          end
          ARB_B: begin
            id_d  = {id_q[27:0], bit_i};
            crc_d = crc_step(crc_q, bit_i);
            if (cnt_q == 7'd17) begin
              cnt_d   = '0;
              state_d = RTR;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          RTR: begin
            rtr_d   = bit_i;
            crc_d   = crc_step(crc_q, bit_i);
            state_d = R1;
          end
          R1: begin
            crc_d   = crc_step(crc_q, bit_i);
            state_d = R0;
          end
          R0: begin
            crc_d   = crc_step(crc_q, bit_i);
            state_d = DLC;
          end
          DLC: begin
            dlc_d = dlc_full;
            crc_d = crc_step(crc_q, bit_i);
            if (cnt_q == 7'd3) begin
              cnt_d       = '0;
              data_bits_d = n_bits;
              state_d     = (n_bits == 7'd0) ? CRC : DATA;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          DATA: begin
            data_d[6'd63 - cnt_q[5:0]] = bit_i;
            crc_d = crc_step(crc_q, bit_i);
            if (cnt_q == data_bits_q - 7'd1) begin
              cnt_d   = '0;
              state_d = CRC;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          CRC: begin
            crc_rx_d = {crc_rx_q[13:0], bit_i};
            if (cnt_q == 7'd14) begin
              cnt_d    = '0;
              crc_ok_d = ({crc_rx_q[13:0], bit_i} == crc_q);
              state_d  = CRC_DEL;
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          CRC_DEL: begin
            if (!bit_i) begin
              err_fire = 1'b1;
              err_code = ERR_FORM;
            end else begin
              ack_d   = crc_ok_q;
              state_d = ACK_SLOT;
            end
          end
          ACK_SLOT: begin
            ack_d   = 1'b0;
            state_d = ACK_DEL;
          end
          ACK_DEL: begin
            if (!crc_ok_q) begin
              err_fire = 1'b1;
              err_code = ERR_CRC;
            end else if (!bit_i) begin
              err_fire = 1'b1;
              err_code = ERR_FORM;
            end else begin
              cnt_d   = '0;
              state_d = EOF;
            end
          end
          EOF: begin
            if (!bit_i) begin
              err_fire = 1'b1;
              err_code = ERR_FORM;
            end else if (cnt_q == 7'd6) begin
              cnt_d   = '0;
              state_d = IDLE;
              if (frame_accept) begin
                valid_d    = 1'b1;
                out_id_d   = id_q;
                out_rtr_d  = rtr_q;
                out_dlc_d  = dlc_q;
                out_data_d = data_q;
              end
            end else begin
              cnt_d = cnt_q + 7'd1;
            end
          end
          default: ;
        endcase
      end
    end

    if (err_fire) begin
      error_d = 1'b1;
      code_d  = err_code;
      ack_d   = 1'b0;
      cnt_d   = '0;
      state_d = WAIT_IDLE;
    end

    busy_d = !((state_d == IDLE) || (state_d == WAIT_IDLE));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WAIT_IDLE;
      cnt_q       <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      crc_ok_q    <= 1'b0;
      id_q        <= '0;
      rtr_q       <= 1'b0;
      dlc_q       <= '0;
      data_q      <= '0;
      data_bits_q <= '0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= '0;
      out_id_q    <= '0;
      out_rtr_q   <= 1'b0;
      out_dlc_q   <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_q       <= run_d;
      last_q      <= last_d;
      crc_q       <= crc_d;
      crc_rx_q    <= crc_rx_d;
      crc_ok_q    <= crc_ok_d;
      id_q        <= id_d;
      rtr_q       <= rtr_d;
      dlc_q       <= dlc_d;
      data_q      <= data_d;
      data_bits_q <= data_bits_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      error_q     <= error_d;
      code_q      <= code_d;
      out_id_q    <= out_id_d;
      out_rtr_q   <= out_rtr_d;
      out_dlc_q   <= out_dlc_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ack_o            = ack_q;
  assign busy_o           = busy_q;
  assign frame_valid_o    = valid_q;
  assign error_o          = error_q;
  assign error_code_o     = code_q;
  assign message_type_o   = out_id_q[28];
  assign local_address_o  = out_id_q[27:22];
  assign remote_address_o = out_id_q[21:16];
  assign handshake_o      = out_id_q[15:14];
  assign attribute_o      = out_id_q[13:12];
  assign expand_count_o   = out_id_q[11:8];
  assign cmd_data_sign_o  = out_id_q[7:0];
  assign rtr_o            = out_rtr_q;
  assign dlc_o            = out_dlc_q;
  assign data_o           = out_data_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_can_frame_decoder.sv
// Directed-vector bench for can_frame_decoder: a bench-side encoder builds stuffed frames, a scoreboard checks every output event.
`timescale 1ns/1ps
module tb_can_frame_decoder;

  localparam int W = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        bit_in;
  logic        ack_o, busy_o, frame_valid_o, error_o, rtr_o, message_type_o;
  logic [5:0]  local_address_o, remote_address_o;
  logic [1:0]  handshake_o, attribute_o;
  logic [3:0]  expand_count_o, dlc_o, state_o;
  logic [7:0]  cmd_data_sign_o;
  logic [63:0] data_o;
  logic [2:0]  error_code_o;

  int tests_run = 0;
  int tests_failed = 0;

  logic [W-1:0] exp_q[$];
  logic         raw_q[$];
  logic         tx_q[$];
  int           stf_tx_q[$];
  int           stf_raw_q[$];

  logic [28:0]  last_id;
  logic         last_rtr;
  logic [3:0]   last_dlc;
  logic [63:0]  last_data;
  logic [2:0]   last_code;

  can_frame_decoder dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .bit_valid_i      (bit_valid),
    .bit_i            (bit_in),
    .ack_o            (ack_o),
    .busy_o           (busy_o),
    .frame_valid_o    (frame_valid_o),
    .message_type_o   (message_type_o),
    .local_address_o  (local_address_o),
    .remote_address_o (remote_address_o),
    .handshake_o      (handshake_o),
    .attribute_o      (attribute_o),
    .expand_count_o   (expand_count_o),
    .cmd_data_sign_o  (cmd_data_sign_o),
    .rtr_o            (rtr_o),
    .dlc_o            (dlc_o),
    .data_o           (data_o),
    .error_o          (error_o),
    .error_code_o     (error_code_o),
    .state_o          (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [1:0] kind, input logic [2:0] code,
                                        input logic [28:0] id, input logic rtr,
                                        input logic [3:0] dlc, input logic [63:0] data);
    return W'({kind, code, id, rtr, dlc, data});
  endfunction

  function automatic logic [W-1:0] dut_event();
    return pack({frame_valid_o, error_o}, error_code_o,
                {message_type_o, local_address_o, remote_address_o, handshake_o,
                 attribute_o, expand_count_o, cmd_data_sign_o},
                rtr_o, dlc_o, data_o);
  endfunction

  task automatic push_valid(input logic [28:0] id, input logic rtr, input logic [3:0] dlc,
                            input logic [63:0] data);
    last_id = id; last_rtr = rtr; last_dlc = dlc; last_data = data;
    exp_q.push_back(pack(2'b10, last_code, id, rtr, dlc, data));
  endtask

  task automatic push_error(input logic [2:0] code);
    last_code = code;
    exp_q.push_back(pack(2'b01, code, last_id, last_rtr, last_dlc, last_data));
  endtask

  task automatic clear_last();
    last_id = '0; last_rtr = 1'b0; last_dlc = '0; last_data = '0; last_code = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && (frame_valid_o || error_o)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_event: got %0h expected none", dut_event());
      end else begin
        check("event", dut_event(), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver / encoder ----------------
  task automatic send_bit(input logic b);
    int gap;
    gap = $urandom_range(0, 1);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bit_valid = 1'b1;
    bit_in    = b;
    @(negedge clk);
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic build_raw(input logic [28:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data, input int crc_flip);
    logic [14:0] crc;
    logic        nxt;
    int          nb;
    raw_q.delete();
    raw_q.push_back(1'b0);
    for (int i = 28; i >= 18; i--) raw_q.push_back(id[i]);
    raw_q.push_back(1'b1);
    raw_q.push_back(1'b1);
    for (int i = 17; i >= 0; i--) raw_q.push_back(id[i]);
    raw_q.push_back(rtr);
    raw_q.push_back(1'b0);
    raw_q.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw_q.push_back(dlc[i]);
    nb = rtr ? 0 : ((dlc > 4'd8) ? 64 : 8 * int'(dlc));
    for (int i = 0; i < nb; i++) raw_q.push_back(data[63 - i]);
    crc = '0;
    for (int i = 0; i < raw_q.size(); i++) begin
      nxt = raw_q[i] ^ crc[14];
      crc = {crc[13:0], 1'b0};
      if (nxt) crc = crc ^ 15'h4599;
    end
    if (crc_flip >= 0) crc[crc_flip] = ~crc[crc_flip];
    for (int i = 14; i >= 0; i--) raw_q.push_back(crc[i]);
  endtask

  task automatic do_stuff();
    int   run;
    logic last;
    tx_q.delete(); stf_tx_q.delete(); stf_raw_q.delete();
    run = 0; last = 1'b1;
    for (int i = 0; i < raw_q.size(); i++) begin
      tx_q.push_back(raw_q[i]);
      if (i > 0 && raw_q[i] == last) run++;
      else run = 1;
      last = raw_q[i];
      if (run == 5) begin
        stf_tx_q.push_back(tx_q.size());
        stf_raw_q.push_back(i);
        tx_q.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
  endtask

  task automatic send_frame(input logic exp_ack, input logic exp_crc_err, input logic exp_valid);
    for (int i = 0; i < tx_q.size(); i++) begin
      send_bit(tx_q[i]);
      if (i == 0) check("busy_after_sof", W'(busy_o), W'(1'b1));
    end
    send_bit(1'b1);
    check("ack_after_crc_del", W'(ack_o), W'(exp_ack));
    send_bit(exp_ack ? 1'b0 : 1'b1);
    check("ack_after_ack_slot", W'(ack_o), W'(1'b0));
    send_bit(1'b1);
    check("error_after_ack_del", W'(error_o), W'(exp_crc_err));
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    check("valid_after_eof", W'(frame_valid_o), W'(exp_valid));
    check("busy_after_eof", W'(busy_o), W'(1'b0));
  endtask

  task automatic run_frame(input logic [28:0] id, input logic rtr, input logic [3:0] dlc,
                           input logic [63:0] data, input logic [63:0] exp_data,
                           input int crc_flip, input logic exp_valid);
    build_raw(id, rtr, dlc, data, crc_flip);
    do_stuff();
    if (crc_flip >= 0) push_error(3'b011);
    else if (exp_valid) push_valid(id, rtr, dlc, exp_data);
    send_frame(crc_flip < 0, crc_flip >= 0, exp_valid && (crc_flip < 0));
    if (crc_flip >= 0) send_idle(11);
    else send_idle(2);
  endtask

  task automatic check_all_zero(input string name);
    check(name, dut_event(), '0);
    check({name, "_ack_busy"}, W'({ack_o, busy_o}), W'(2'b00));
    check({name, "_state"}, W'(state_o), W'(4'd0));
  endtask

  // ---------------- stimulus ----------------
  localparam logic [28:0] ID_A = {1'b0, 6'b000101, 6'b100010, 2'b10, 2'b10, 4'b1011, 8'hF5};
  localparam logic [28:0] ID_S = {1'b1, 6'b110011, 6'b100010, 2'b00, 2'b00, 4'b0000, 8'h5A};
  localparam logic [28:0] ID_R = {1'b1, 6'b000001, 6'b100010, 2'b01, 2'b11, 4'b0110, 8'h3C};
  localparam logic [28:0] ID_F = {1'b0, 6'b001010, 6'b100011, 2'b11, 2'b01, 4'b1001, 8'h81};
  localparam logic [28:0] ID_B = {1'b1, 6'b111000, 6'b111111, 2'b10, 2'b01, 4'b1111, 8'h00};
  localparam logic [63:0] DATA_A = 64'h3132333435363738;

  initial begin
    int flip_idx;
    logic filt;
`ifdef CAN_DEC_ADDR_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    clear_last();
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");

    // SOF before 11 recessive bits is ignored
    send_bit(1'b0);
    check("sof_ignored_after_reset", W'(busy_o), W'(1'b0));
    send_idle(11);

    run_frame(ID_A, 1'b0, 4'd9, DATA_A, DATA_A, -1, 1'b1);

    // stuff error: first stuff bit inside ARB_B that ends a dominant run is flipped
    build_raw(ID_S, 1'b0, 4'd3, 64'h1122334455667788, -1);
    do_stuff();
    flip_idx = -1;
    for (int j = 0; j < stf_tx_q.size(); j++)
      if (flip_idx < 0 && stf_raw_q[j] >= 14 && stf_raw_q[j] <= 31 && tx_q[stf_tx_q[j]] == 1'b1)
        flip_idx = stf_tx_q[j];
    if (flip_idx < 0) begin
      tests_run++; tests_failed++;
      $display("FAIL stuff_setup: got no stuff bit expected one in ARB_B");
    end else begin
      tx_q[flip_idx] = 1'b0;
      push_error(3'b001);
      for (int i = 0; i <= flip_idx; i++) send_bit(tx_q[i]);
      check("stuff_error_pulse", W'({error_o, error_code_o, ack_o}), W'({1'b1, 3'b001, 1'b0}));
      send_idle(11);
    end

    run_frame(ID_S, 1'b0, 4'd3, 64'h1122334455667788, 64'h1122330000000000, -1, 1'b1);
    run_frame(ID_A, 1'b0, 4'd9, DATA_A, DATA_A, 7, 1'b0);
    run_frame(ID_R, 1'b1, 4'd4, 64'hDEADBEEFCAFEF00D, 64'h0, -1, 1'b1);
    run_frame(ID_F, 1'b0, 4'd1, 64'hABCDEF0123456789, 64'hAB00000000000000, -1, !filt);
    run_frame(ID_B, 1'b0, 4'd8, 64'h0102040810204080, 64'h0102040810204080, -1, 1'b1);
    run_frame(ID_A, 1'b0, 4'd0, DATA_A, 64'h0, -1, 1'b1);

    // reset mid-DATA, with a strobe in the reset cycle
    build_raw(ID_A, 1'b0, 4'd9, DATA_A, -1);
    do_stuff();
    for (int i = 0; i < 50; i++) send_bit(tx_q[i]);
    check("busy_mid_frame", W'(busy_o), W'(1'b1));
    @(negedge clk);
    rst = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b1;
    clear_last();
    check_all_zero("mid_frame_reset");
    send_idle(3);
    send_bit(1'b0);
    check("sof_ignored_after_mid_reset", W'(busy_o), W'(1'b0));
    send_idle(11);
    run_frame(ID_A, 1'b0, 4'd9, DATA_A, DATA_A, -1, 1'b1);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/can_frame_decoder.md
# can_frame_decoder

Receive-side frame decoder for the extended-format CAN link driven by the transmit path. Consumes one sampled bus bit per sample-point strobe from the bit-timing logic. Removes stuff bits, checks CRC-15 and frame form, and requests the ACK-slot dominant bit. Splits the 29-bit identifier into the node protocol fields (message type, addresses, handshake, attribute, expand count, command/data sign) and presents them with DLC and payload as one validated frame.

## Interface
- NODE_ADDRESS, 6'b100010, this node's address; used only by the address filter.
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- bit_valid_i  in  1  one-cycle strobe at the bit sample point; may be back-to-back.
- bit_i  in  1  sampled bus level, 0 = dominant.
- ack_o  out  1  1 = drive the bus dominant, ACK slot only.
- busy_o  out  1  high from the SOF until the decoder returns to IDLE.
- frame_valid_o  out  1  one-cycle pulse; field outputs are valid.
- message_type_o  out  1; local_address_o  out  6; remote_address_o  out  6; handshake_o  out  2; attribute_o  out  2; expand_count_o  out  4; cmd_data_sign_o  out  8.
- rtr_o  out  1; dlc_o  out  4; data_o  out  64.
- error_o  out  1  one-cycle error pulse.
- error_code_o  out  3  error code: 001 stuff, 010 form, 011 CRC. Holds until the next error.

## Operation
- ID[28:0] = {message_type, local_address, remote_address, handshake, attribute, expand_count, cmd_data_sign}, sent MSB first.
- ID_A = ID[28:18]; ID_B = ID[17:0].
- States, each advanced only on bit_valid_i:
  - WAIT_IDLE: count 11 consecutive recessive bits; any dominant bit clears the count; then go to IDLE.
  - IDLE: a dominant bit is the SOF; go to ARB_A.
  - Field sequence: ARB_A(11), SRR(1), IDE(1), ARB_B(18), RTR(1), R1(1), R0(1), DLC(4), DATA(8·n), CRC(15), CRC_DEL, ACK_SLOT, ACK_DEL, EOF(7), then IDLE.
- n = 0 if RTR = 1; otherwise min(DLC, 8). With n = 0, DLC goes straight to CRC.
- Destuffing applies from SOF through the last CRC bit:
  - A run counter tracks consecutive equal bits.
  - After a run of 5, the next bit is a stuff bit. It must be the opposite level and is discarded: not shifted and not fed to the CRC. The run then restarts at 1 with the stuff bit's level.
  - If the bit after a run of 5 has the same level: stuff error.
  - The CRC field's own trailing bits can require a stuff bit; that stuff bit is checked as above.
- CRC-15 uses polynomial 0x4599 and init 0. It covers destuffed bits SOF through the last data bit; the result is compared with the received CRC.
- Form error on any of:
  - SRR = 0 or IDE = 0 (standard frames are unsupported);
  - CRC_DEL, ACK_DEL or any EOF bit dominant.
- R1/R0 may take any value.
- ACK and frame acceptance:
  - If the CRC matches: ack_o = 1 through the ACK slot.
  - If the CRC mismatches: CRC error is signalled on the ACK_DEL strobe, and there is no ack.
- Any error: error_o pulses with the code, then go to WAIT_IDLE. No frame_valid_o; field outputs are unchanged.
- data_o: first received byte lands in [63:56]; unreceived low bytes are 0; RTR gives data_o = 0.
- Field outputs update only together with frame_valid_o and hold until the next valid frame.

## Timing
- Reset: all outputs 0 and state WAIT_IDLE (an SOF is ignored until 11 recessive bits). Reset in the same cycle as bit_valid_i: reset wins.
- Each strobe is processed in its own cycle; registered outputs change in the cycle after the strobe.
- busy_o: rises the cycle after the SOF strobe; falls the cycle after the final EOF strobe or the error strobe.
- ack_o: rises the cycle after the CRC_DEL strobe and falls the cycle after the ACK_SLOT strobe.
- error_o: asserted the cycle after the offending strobe.
- frame_valid_o: asserted the cycle after the 7th EOF strobe, only if the frame had no error.
- A dominant bit on the strobe right after EOF returns to IDLE is accepted as a new SOF (no intermission check).

## Configuration
- CAN_DEC_ADDR_FILTER_EN defined:
  - frame_valid_o pulses only if remote_address == NODE_ADDRESS or remote_address == 6'h3F (broadcast).
  - Filtered frames still get ack_o but leave the outputs unchanged.
- CAN_DEC_ADDR_FILTER_EN undefined: every error-free frame gives frame_valid_o; NODE_ADDRESS is unused.

## Test plan
- Correctly stuffed frame with message_type 0, local 6'b000101, remote 6'b100010, handshake 2'b10, attribute 2'b10, expand 4'b1011, cmd 8'hF5, DLC 9, data 64'h3132333435363738 -> ack_o high over the ACK slot and one frame_valid_o pulse. Outputs match, with dlc_o = 9 and data_o = 64'h3132333435363738.
- Six consecutive dominant bits inside ARB_B -> error_o with code 001 on the cycle after the 6th bit; no ack, no valid. After 11 recessive bits, the next good frame decodes.
- One CRC bit flipped (restuffed) -> ack_o stays 0; code 011 on the cycle after ACK_DEL; no valid.
- RTR = 1, DLC = 4 -> valid, dlc_o = 4, rtr_o = 1, data_o = 0.
- With CAN_DEC_ADDR_FILTER_EN and remote 6'b100011 -> ack given, no frame_valid_o. Without the macro -> valid. Remote 6'h3F -> valid in both builds.
- rst_i asserted mid-DATA -> all outputs 0 the next cycle. An SOF 3 bits later is ignored; a frame after 11 recessive bits decodes.
